// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one combinational ALU. Each port has a
// valid/ready request handshake, arbitration is round-robin or fixed
// priority, and the result lands in a single registered response slot that
// carries the issuing port and the request tag.
//
// Handshake semantics: a transfer happens on any rising edge where valid and
// ready are both high. A requester raises valid without looking at ready,
// then holds valid and every field stable until it sees ready. The response
// slot uses the same rule: o_rsp_valid stays high and o_rsp_* stay frozen
// until the edge that also sees i_rsp_ready. Readys depend combinationally on
// the valids, the slot state and i_rsp_ready. No valid depends on a ready.
module alu_arbiter #(
  parameter int TAG_W      = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [2:0]       i_req0_opsel,
  input  logic             i_req0_sub,
  input  logic             i_req0_unsigned,
  input  logic             i_req0_arith,
  input  logic [31:0]      i_req0_op1,
  input  logic [31:0]      i_req0_op2,
  input  logic [TAG_W-1:0] i_req0_tag,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [2:0]       i_req1_opsel,
  input  logic             i_req1_sub,
  input  logic             i_req1_unsigned,
  input  logic             i_req1_arith,
  input  logic [31:0]      i_req1_op1,
  input  logic [31:0]      i_req1_op2,
  input  logic [TAG_W-1:0] i_req1_tag,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [31:0]      o_rsp_result,
  output logic             o_rsp_eq,
  output logic             o_rsp_slt,
  output logic             o_rsp_src,
  output logic [TAG_W-1:0] o_rsp_tag
);

  localparam bit FIXED = (FIXED_PRIO != 0);

  // r_last_gnt: port granted on the most recent accepted transfer. Reset
  // value 1 makes port 0 win the first contended cycle.
  logic             r_last_gnt;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_result;
  logic             r_rsp_eq;
  logic             r_rsp_slt;
  logic             r_rsp_src;
  logic [TAG_W-1:0] r_rsp_tag;

  logic             w_can_accept;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_fire;
  logic [2:0]       w_opsel;
  logic             w_sub;
  logic             w_unsigned;
  logic             w_arith;
  logic [31:0]      w_op1;
  logic [31:0]      w_op2;
  logic [TAG_W-1:0] w_tag;
  logic [4:0]       w_shamt;
  logic             w_lt;
  logic             w_eq;
  logic [31:0]      w_result;

  // A full slot being drained this cycle frees itself for a new accept.
  assign w_can_accept = !r_rsp_valid || i_rsp_ready;

  // Grant selection. Port 1 gets the grant only when port 0 does not, so at
  // most one grant is ever high.
  always_comb begin
    w_gnt0 = i_req0_valid && (!i_req1_valid || FIXED || r_last_gnt);
    w_gnt1 = i_req1_valid && !w_gnt0;
  end

  assign o_req0_ready = i_rst_n && w_can_accept && w_gnt0;
  assign o_req1_ready = i_rst_n && w_can_accept && w_gnt1;
  assign w_fire       = o_req0_ready || o_req1_ready;

  // Steer the granted port's fields into the shared ALU.
  always_comb begin
    w_opsel    = w_gnt1 ? i_req1_opsel    : i_req0_opsel;
    w_sub      = w_gnt1 ? i_req1_sub      : i_req0_sub;
    w_unsigned = w_gnt1 ? i_req1_unsigned : i_req0_unsigned;
    w_arith    = w_gnt1 ? i_req1_arith    : i_req0_arith;
    w_op1      = w_gnt1 ? i_req1_op1      : i_req0_op1;
    w_op2      = w_gnt1 ? i_req1_op2      : i_req0_op2;
    w_tag      = w_gnt1 ? i_req1_tag      : i_req0_tag;
  end

  // The shared ALU. Flags are computed for every opsel. Shifts use op2[4:0].
  always_comb begin
    w_shamt = w_op2[4:0];
    w_eq    = (w_op1 == w_op2);
    w_lt    = w_unsigned ? (w_op1 < w_op2) : ($signed(w_op1) < $signed(w_op2));
    w_result = '0;
    unique case (w_opsel)
      3'b000:         w_result = w_sub ? (w_op1 - w_op2) : (w_op1 + w_op2);
      3'b001:         w_result = w_op1 << w_shamt;
      3'b010, 3'b011: w_result = {31'd0, w_lt};
      3'b100:         w_result = w_op1 ^ w_op2;
      3'b101:         w_result = w_arith ? 32'($signed(w_op1) >>> w_shamt)
                                         : (w_op1 >> w_shamt);
      3'b110:         w_result = w_op1 | w_op2;
      3'b111:         w_result = w_op1 & w_op2;
      default:        w_result = '0;
    endcase
  end

  // Response slot and round-robin pointer. Accepting a request reloads the
  // slot. Draining without a new accept clears only the valid bit.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_last_gnt   <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_eq     <= 1'b0;
      r_rsp_slt    <= 1'b0;
      r_rsp_src    <= 1'b0;
      r_rsp_tag    <= '0;
    end else if (w_fire) begin
      r_last_gnt   <= w_gnt1;
      r_rsp_valid  <= 1'b1;
      r_rsp_result <= w_result;
      r_rsp_eq     <= w_eq;
      r_rsp_slt    <= w_lt;
      r_rsp_src    <= w_gnt1;
      r_rsp_tag    <= w_tag;
    end else if (i_rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_eq     = r_rsp_eq;
  assign o_rsp_slt    = r_rsp_slt;
  assign o_rsp_src    = r_rsp_src;
  assign o_rsp_tag    = r_rsp_tag;

endmodule
